// File: rtl/pbs_pkg.sv
// pbs_pkg: shared state/op encodings and helpers for the battle turn scheduler.
package pbs_pkg;
  typedef enum logic [3:0] {
    IDLE, LOAD, WAIT_GO, P_SEL, P_RESOLVE, P_CHECK, AI_SEL, AI_RESOLVE, AI_CHECK, WIN, LOSE
  } st_e;
  typedef enum logic [1:0] {OP_ATTACK, OP_HEAL, OP_CATCH, OP_RUN} op_e;
  // 11 states squeezed into a 3-bit LED code: each half-turn phase group shares one code
  function automatic logic [2:0] st_code(input st_e s);
    return (s == IDLE) ? 3'd0 : (s == LOAD) ? 3'd1 : (s == WAIT_GO) ? 3'd2 :
           (s inside {P_SEL, P_RESOLVE, P_CHECK}) ? 3'd3 :
           (s inside {AI_SEL, AI_RESOLVE, AI_CHECK}) ? 3'd4 : (s == WIN) ? 3'd5 : 3'd6;
  endfunction
  function automatic logic hit_rule(input logic [3:0] accu, input logic [3:0] r);
    return (accu == 4'hF) | (r < accu);
  endfunction
endpackage

// File: rtl/pbs_lfsr8.sv
// pbs_lfsr8: free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
module pbs_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= SEED;
    else q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/pbs_turn_sched.sv
// pbs_turn_sched: sequences one player half-turn and one AI half-turn per go press.
module pbs_turn_sched import pbs_pkg::*; #(
  parameter logic [7:0] LFSR_SEED    = 8'hA5,
  parameter int         CATCH_HP_MAX = 4,
  parameter int         CATCH_ODDS   = 8,
  parameter int         MAX_TURNS    = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] p_op,
  input  logic [1:0] p_move,
  input  logic [3:0] dmg,
  input  logic [3:0] accu,
  input  logic [3:0] ai_hp,
  input  logic       ai_dead,
  input  logic       p_dead,
  input  logic       dbg_rng_en,
  input  logic [7:0] dbg_rng,
  output logic [1:0] move_sel,
  output logic       active_trainer,
  output logic       load_ai_hp,
  output logic       apply_ai_damage,
  output logic       apply_p_damage,
  output logic       p_heal,
  output logic       catch,
  output logic       catch_fail,
  output logic       hit,
  output logic       busy,
  output logic       victory,
  output logic       loss,
  output logic       caught,
  output logic [6:0] turn_count,
  output logic [2:0] state
);
  localparam logic [3:0] HP_MAX = 4'(CATCH_HP_MAX);
  localparam logic [3:0] ODDS   = 4'(CATCH_ODDS);
  localparam logic [6:0] TMAX   = 7'(MAX_TURNS);
  st_e        st, st_nx;
  op_e        op_q;
  logic       go_q, armed, hit_now, catch_ok, go_edge;
  logic [7:0] lfsr, rng;
  logic [6:0] tc_nx;
  pbs_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
  assign rng      = dbg_rng_en ? dbg_rng : lfsr;
  assign hit_now  = hit_rule(accu, rng[3:0]);
  assign catch_ok = (ai_hp <= HP_MAX) && (rng[7:4] < ODDS);
  assign go_edge  = go & ~go_q;
  assign tc_nx    = turn_count + 7'd1;
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:       st_nx = armed ? LOAD : IDLE;
      LOAD:       st_nx = WAIT_GO;
      WAIT_GO:    st_nx = go_edge ? P_SEL : WAIT_GO;
      P_SEL:      st_nx = P_RESOLVE;
      P_RESOLVE:  st_nx = (op_q == OP_RUN) ? LOSE : (op_q == OP_CATCH && catch_ok) ? WIN : P_CHECK;
      P_CHECK:    st_nx = ai_dead ? WIN : AI_SEL;
      AI_SEL:     st_nx = AI_RESOLVE;
      AI_RESOLVE: st_nx = AI_CHECK;
      AI_CHECK:   st_nx = (p_dead || tc_nx == TMAX) ? LOSE : WAIT_GO;
      default:    st_nx = st;
    endcase
  end
  assign load_ai_hp      = st == LOAD;
  assign apply_ai_damage = st == P_RESOLVE && op_q == OP_ATTACK && hit_now && dmg != 4'd0;
  assign apply_p_damage  = st == AI_RESOLVE && hit_now && dmg != 4'd0;
  assign p_heal          = st == P_RESOLVE && op_q == OP_HEAL;
  assign catch           = st == P_RESOLVE && op_q == OP_CATCH && catch_ok;
  assign catch_fail      = st == P_RESOLVE && op_q == OP_CATCH && !catch_ok;
  assign busy            = st inside {P_SEL, P_RESOLVE, P_CHECK, AI_SEL, AI_RESOLVE, AI_CHECK};
  assign victory         = st == WIN;
  assign loss            = st == LOSE;
  assign state           = st_code(st);
  // go_q resets high so a go level held through reset is not seen as an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st             <= IDLE;
      go_q           <= 1'b1;
      armed          <= 1'b0;
      op_q           <= OP_ATTACK;
      move_sel       <= 2'd0;
      active_trainer <= 1'b0;
      hit            <= 1'b0;
      caught         <= 1'b0;
      turn_count     <= 7'd0;
    end else begin
      st    <= st_nx;
      go_q  <= go;
      armed <= 1'b1;
      if (st == WAIT_GO && go_edge) begin
        op_q           <= op_e'(p_op);
        move_sel       <= p_move;
        active_trainer <= 1'b0;
      end
      if (st == P_CHECK && !ai_dead) begin
        move_sel       <= rng[1:0];
        active_trainer <= 1'b1;
      end
      if ((st == P_RESOLVE && op_q == OP_ATTACK) || st == AI_RESOLVE) hit <= hit_now;
      if (catch) caught <= 1'b1;
      if (st == AI_CHECK && !p_dead && turn_count < TMAX) turn_count <= tc_nx;
    end
endmodule
